// File: rtl/alu_serie.sv
// Bit-serial N-bit ALU: operands shift through one 1-bit cal cell, LSB first,
// with the carry and the result bits captured back into registers.

module cal (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_c,
  input  logic       i_l,
  input  logic [1:0] i_s,
  output logic       o_r,
  output logic       o_c
);

  logic w_sum;
  logic w_log;

  assign w_sum = i_a ^ i_b ^ i_c;
  assign o_c   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

  always_comb begin
    w_log = 1'b0;
    case (i_s)
      2'b00:   w_log = i_a & i_b;
      2'b01:   w_log = i_a | i_b;
      2'b10:   w_log = i_a ^ i_b;
      default: w_log = ~i_a;
    endcase
  end

  assign o_r = i_l ? w_log : w_sum;

endmodule

// Handshake: i_start is sampled only while idle; an accepted request keeps
// o_busy high until the cycle after the single-cycle o_done pulse. There is
// no back-pressure and no queuing; a start seen while busy is dropped.
module alu_serie #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_l,
  input  logic [1:0]   i_s,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_r,
  output logic         o_c_out,
  output logic         o_v,
  output logic         o_z,
  output logic [1:0]   o_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_r;
  logic          r_l;
  logic [1:0]    r_s;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic          r_c_out;
  logic          r_v;
  logic          r_z;

  logic          w_b_bit;
  logic          w_cell_r;
  logic          w_cell_c;
  logic          w_last;
  logic [N-1:0]  w_r_next;
  logic          w_busy;
  logic          w_done;

  // Subtract feeds ~B into the adder; the +1 comes from the preset carry.
  assign w_b_bit  = r_b[0] ^ (~r_l & r_s[0]);
  assign w_last   = (r_cnt == LAST);
  assign w_r_next = {w_cell_r, r_r[N-1:1]};

  cal u_cal (
    .i_a (r_a[0]),
    .i_b (w_b_bit),
    .i_c (r_carry),
    .i_l (r_l),
    .i_s (r_s),
    .o_r (w_cell_r),
    .o_c (w_cell_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Flags are captured on the MSB step itself, so they are valid together
  // with the done pulse and hold until the next accepted start clears them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_l     <= 1'b0;
      r_s     <= 2'b00;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_c_out <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_l     <= i_l;
            r_s     <= i_s;
            r_r     <= '0;
            r_cnt   <= '0;
            r_carry <= ~i_l & i_s[0];
            r_c_out <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_r     <= w_r_next;
          r_carry <= w_cell_c;
          if (w_last) begin
            r_c_out <= ~r_l & w_cell_c;
            r_v     <= ~r_l & (r_carry ^ w_cell_c);
            r_z     <= (w_r_next == '0);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign o_busy  = w_busy;
  assign o_done  = w_done;
  assign o_r     = r_r;
  assign o_c_out = r_c_out;
  assign o_v     = r_v;
  assign o_z     = r_z;
  assign o_state = r_state;

endmodule
